// File: rtl/control_unit.sv
// Sequencing controller for the 8-bit RISC-SPM processing unit.
// Fetches, decodes and drives every datapath strobe, one instruction at a time.
module control_unit #(
    parameter int word_size = 8,
    parameter int op_size   = 4,
    parameter int Sel1_size = 3,
    parameter int Sel2_size = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] instruction,
    input  logic                 zero,
    output logic                 Load_R0,
    output logic                 Load_R1,
    output logic                 Load_R2,
    output logic                 Load_R3,
    output logic                 Load_PC,
    output logic                 Inc_PC,
    output logic                 Load_IR,
    output logic                 Load_Add_R,
    output logic                 Load_Reg_Y,
    output logic                 Load_Reg_Z,
    output logic [Sel1_size-1:0] Sel_Bus_1_Mux,
    output logic [Sel2_size-1:0] Sel_Bus_2_Mux,
    output logic                 write,
    output logic                 halted
);

    typedef enum logic [3:0] {
        S_idle, S_fet1, S_fet2, S_dec, S_ex1,
        S_rd1, S_rd2, S_wr1, S_wr2, S_br1, S_br2, S_halt
    } state_t;

    localparam logic [op_size-1:0] OP_NOP = 0;
    localparam logic [op_size-1:0] OP_ADD = 1;
    localparam logic [op_size-1:0] OP_SUB = 2;
    localparam logic [op_size-1:0] OP_AND = 3;
    localparam logic [op_size-1:0] OP_NOT = 4;
    localparam logic [op_size-1:0] OP_RD  = 5;
    localparam logic [op_size-1:0] OP_WR  = 6;
    localparam logic [op_size-1:0] OP_BR  = 7;
    localparam logic [op_size-1:0] OP_BRZ = 8;

    localparam logic [Sel1_size-1:0] SEL1_PC  = 4;
    localparam logic [Sel2_size-1:0] SEL2_ALU = 0;
    localparam logic [Sel2_size-1:0] SEL2_B1  = 1;
    localparam logic [Sel2_size-1:0] SEL2_MEM = 2;

    state_t state, next;

    logic [op_size-1:0]   opcode;
    logic [Sel1_size-1:0] src, dest;
    logic [3:0]           load_r, dest_dec;

    assign opcode   = instruction[word_size-1 -: op_size];
    assign src      = Sel1_size'(instruction[3:2]);
    assign dest     = Sel1_size'(instruction[1:0]);
    assign dest_dec = 4'b0001 << instruction[1:0];

    assign {Load_R3, Load_R2, Load_R1, Load_R0} = load_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_idle;
        else     state <= next;
    end

    always_comb begin
        next          = state;
        load_r        = '0;
        Load_PC       = 1'b0;
        Inc_PC        = 1'b0;
        Load_IR       = 1'b0;
        Load_Add_R    = 1'b0;
        Load_Reg_Y    = 1'b0;
        Load_Reg_Z    = 1'b0;
        Sel_Bus_1_Mux = '0;
        Sel_Bus_2_Mux = '0;
        write         = 1'b0;
        halted        = 1'b0;
        unique case (state)
            S_idle: next = S_fet1;
            S_fet1: begin
                Sel_Bus_1_Mux = SEL1_PC;
                Sel_Bus_2_Mux = SEL2_B1;
                Load_Add_R    = 1'b1;
                Inc_PC        = 1'b1;
                next          = S_fet2;
            end
            S_fet2: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_IR       = 1'b1;
                next          = S_dec;
            end
            S_dec: begin
                case (opcode)
                    OP_NOP: next = S_fet1;
                    OP_ADD, OP_SUB, OP_AND: begin
                        Sel_Bus_1_Mux = src;
                        Sel_Bus_2_Mux = SEL2_B1;
                        Load_Reg_Y    = 1'b1;
                        next          = S_ex1;
                    end
                    OP_NOT: begin
                        Sel_Bus_1_Mux = src;
                        Sel_Bus_2_Mux = SEL2_ALU;
                        Load_Reg_Z    = 1'b1;
                        load_r        = dest_dec;
                        next          = S_fet1;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        Sel_Bus_1_Mux = SEL1_PC;
                        Sel_Bus_2_Mux = SEL2_B1;
                        Load_Add_R    = 1'b1;
                        next = (opcode == OP_RD) ? S_rd1 :
                               (opcode == OP_WR) ? S_wr1 : S_br1;
                    end
                    OP_BRZ: begin
                        if (zero) begin
                            Sel_Bus_1_Mux = SEL1_PC;
                            Sel_Bus_2_Mux = SEL2_B1;
                            Load_Add_R    = 1'b1;
                            next          = S_br1;
                        end else begin
                            // not taken: step over the branch address word
                            Inc_PC = 1'b1;
                            next   = S_fet1;
                        end
                    end
                    default: next = S_halt;
                endcase
            end
            S_ex1: begin
                Sel_Bus_1_Mux = dest;
                Sel_Bus_2_Mux = SEL2_ALU;
                Load_Reg_Z    = 1'b1;
                load_r        = dest_dec;
                next          = S_fet1;
            end
            S_rd1, S_wr1: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_Add_R    = 1'b1;
                Inc_PC        = 1'b1;
                next          = (state == S_rd1) ? S_rd2 : S_wr2;
            end
            S_rd2: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                load_r        = dest_dec;
                next          = S_fet1;
            end
            S_wr2: begin
                Sel_Bus_1_Mux = src;
                write         = 1'b1;
                next          = S_fet1;
            end
            S_br1: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_Add_R    = 1'b1;
                next          = S_br2;
            end
            S_br2: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_PC       = 1'b1;
                next          = S_fet1;
            end
            S_halt: halted = 1'b1;
            default: next = S_idle;
        endcase
    end

endmodule

// File: doc/control_unit.md
# control_unit

Moore/Mealy finite-state controller that sequences the 8-bit RISC-SPM processing unit: it fetches each instruction word from memory, decodes the opcode and drives every load, increment, bus-select and memory-write strobe the datapath needs. It sits between the processing unit and the memory unit. It receives only the instruction register contents and the Z flag, and runs one instruction at a time until HALT or an illegal opcode.

## Interface
Parameters:
- word_size, 8, instruction/data width
- op_size, 4, opcode field width (instruction[7:4])
- Sel1_size, 3, Bus_1 mux select width
- Sel2_size, 2, Bus_2 mux select width

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- instruction  input  word_size  IR contents: [7:4] opcode, [3:2] src, [1:0] dest
- zero  input  1  registered Z flag from datapath
- Load_R0, Load_R1, Load_R2, Load_R3  output  1 each  register load enables
- Load_PC, Inc_PC  output  1 each  PC load from Bus_2 / PC increment
- Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z  output  1 each  IR, address, Y, Z load enables
- Sel_Bus_1_Mux  output  Sel1_size  0..3 = R0..R3, 4 = PC
- Sel_Bus_2_Mux  output  Sel2_size  0 = ALU, 1 = Bus_1, 2 = mem_word
- write  output  1  memory write strobe (address register, Bus_1 data)
- halted  output  1  high while in S_halt

## Operation
- Opcodes: NOP 0, ADD 1, SUB 2, AND 3, NOT 4, RD 5, WR 6, BR 7, BRZ 8, HALT 15; 9–14 illegal.
- State register is 4 bits. Outputs are combinational from state, opcode and zero. All strobes default to 0 and both selects default to 0 in every state unless listed.
- S_idle: no strobes -> S_fet1.
- S_fet1: Sel1=4, Sel2=1, Load_Add_R, Inc_PC -> S_fet2.
- S_fet2: Sel2=2, Load_IR -> S_dec.
- S_dec, by opcode:
  - NOP -> S_fet1.
  - ADD/SUB/AND: Sel1=src, Sel2=1, Load_Reg_Y -> S_ex1.
  - NOT: Sel1=src, Sel2=0, Load_Reg_Z, Load_R[dest] -> S_fet1.
  - RD/WR/BR: Sel1=4, Sel2=1, Load_Add_R -> S_rd1/S_wr1/S_br1.
  - BRZ with zero=1: same as BR -> S_br1.
  - BRZ with zero=0: Inc_PC (skip address word) -> S_fet1.
  - HALT or illegal -> S_halt.
- S_ex1: Sel1=dest, Sel2=0, Load_Reg_Z, Load_R[dest] -> S_fet1.
- S_rd1: Sel2=2, Load_Add_R, Inc_PC -> S_rd2.
- S_rd2: Sel2=2, Load_R[dest] -> S_fet1.
- S_wr1: Sel2=2, Load_Add_R, Inc_PC -> S_wr2.
- S_wr2: Sel1=src, write -> S_fet1.
- S_br1: Sel2=2, Load_Add_R -> S_br2.
- S_br2: Sel2=2, Load_PC -> S_fet1.
- S_halt: halted=1, no strobes; held until rst.
- Exactly one Load_Rn is asserted per register write, selected by the dest field. Load_PC and Inc_PC are never asserted together.

## Timing
- rst high: state forces to S_idle immediately, without waiting for a clock. All outputs read 0, selects read 0 and halted reads 0 while rst is high.
- Reset mid-instruction abandons it. Datapath registers are reset by the same rst.
- Clock cycles per instruction, counted from S_fet1:
  - NOP, NOT, BRZ not taken: 3
  - ADD, SUB, AND: 4
  - RD, WR, BR, BRZ taken: 5
- First S_fet1 occurs one cycle after rst deassertion (S_idle lasts one cycle).
- zero is sampled only in S_dec. It reflects the last ALU op, because Load_Reg_Z is only asserted in S_ex1/NOT.
- write is high for exactly one cycle (S_wr2) per WR.
- Outputs are glitch-tolerant combinational. The datapath samples them on the next rising edge.

## Test plan
- Reset mid-S_rd1, then release -> all outputs 0 during rst; S_idle, then S_fet1 with Sel1=4, Sel2=1, Load_Add_R=1, Inc_PC=1.
- instruction=8'h16 (ADD src=R1, dest=R2) -> S_dec: Sel1=1, Load_Reg_Y. Next cycle: Sel1=2, Sel2=0, Load_Reg_Z, Load_R2 only. 4 cycles total.
- instruction=8'h53 (RD to R3) -> S_dec Load_Add_R; S_rd1 Inc_PC; S_rd2 Sel2=2 with Load_R3. 5 cycles; PC incremented twice.
- instruction=8'h60 (WR src R0) -> write=1 only in the 5th cycle, Sel1=0. No register load enables at any point.
- instruction=8'h80:
  - zero=0 -> Inc_PC in S_dec, back to S_fet1 after 3 cycles.
  - zero=1 -> Load_PC asserted in cycle 5 with Sel2=2.
- instruction=8'hF0 or 8'h90 -> S_halt after S_dec. halted=1 and zero strobes for 20+ cycles; rst clears halted.
